// File: rtl/saph_fpi_pkg.sv
// Shared types and widths for the shader-core FPU interface (saph_fpi_*).
package saph_fpi_pkg;

  localparam int FPI_DATA_W  = 32;
  localparam int FPI_RD_W    = 5;
  localparam int FPI_OP_W    = 4;
  localparam int FPI_FLAGS_W = 5;

  typedef enum logic [FPI_OP_W-1:0] {
    FPI_ADD  = 4'd0,
    FPI_SUB  = 4'd1,
    FPI_MUL  = 4'd2,
    FPI_DIV  = 4'd3,
    FPI_MIN  = 4'd4,
    FPI_MAX  = 4'd5,
    FPI_SQRT = 4'd6,
    FPI_CMP  = 4'd7
  } fpi_op_t;

  // IEEE exception flags, MSB first: invalid, div-by-zero, overflow, underflow, inexact.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpi_flags_t;

endpackage

// File: rtl/saph_fpi_rob.sv
// Tag-indexed reorder buffer: allocates tags in order, completes them out of order,
// and presents the oldest slot for in-order retirement.
module saph_fpi_rob
  import saph_fpi_pkg::*;
#(
  parameter int depth = 4,
  parameter int tag_w = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alloc,
  input  logic [FPI_RD_W-1:0]   i_alloc_rd,
  output logic [tag_w-1:0]      o_alloc_tag,
  input  logic                  i_comp,
  input  logic [tag_w-1:0]      i_comp_tag,
  input  logic [FPI_DATA_W-1:0] i_comp_data,
  input  fpi_flags_t            i_comp_flags,
  output logic                  o_comp_ok,
  input  logic                  i_retire,
  output logic                  o_head_valid,
  output logic [FPI_RD_W-1:0]   o_head_rd,
  output logic [FPI_DATA_W-1:0] o_head_data,
  output fpi_flags_t            o_head_flags,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int CNT_W = tag_w + 1;

  logic [depth-1:0]      r_busy;
  logic [depth-1:0]      r_done;
  logic [tag_w-1:0]      r_head;
  logic [tag_w-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [FPI_RD_W-1:0]   r_rd    [depth];
  logic [FPI_DATA_W-1:0] r_data  [depth];
  fpi_flags_t            r_flags [depth];

  logic w_comp_accept;

  assign o_alloc_tag   = r_tail;
  assign o_comp_ok     = r_busy[i_comp_tag] & ~r_done[i_comp_tag];
  assign w_comp_accept = i_comp & o_comp_ok;
  assign o_head_valid  = r_busy[r_head] & r_done[r_head];
  assign o_head_rd     = r_rd[r_head];
  assign o_head_data   = r_data[r_head];
  assign o_head_flags  = r_flags[r_head];
  assign o_full        = (r_count == CNT_W'(depth));
  assign o_empty       = (r_count == '0);

  // Alloc hits the tail, retire the head: they only share a slot when empty or full,
  // where one of them is blocked, so the per-bit updates below never collide.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_alloc) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_comp_accept) begin
        r_done[i_comp_tag] <= 1'b1;
      end
      if (i_retire) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_alloc) - CNT_W'(i_retire);
    end
  end

  // NOTE: payload arrays carry no reset; busy/done qualify every read of them.
  always_ff @(posedge clk) begin
    if (i_alloc) begin
      r_rd[r_tail] <= i_alloc_rd;
    end
    if (w_comp_accept) begin
      r_data[i_comp_tag]  <= i_comp_data;
      r_flags[i_comp_tag] <= i_comp_flags;
    end
  end

endmodule

// File: rtl/saph_fpi_requester.sv
// FPU-interface requester: issues tagged FP ops, reorders results, retires in program order.
// Optional sticky accrued-flags register enabled by `SAPH_FPI_REQ_FFLAGS_EN.
module saph_fpi_requester
  import saph_fpi_pkg::*;
#(
  parameter int depth = 4,
  parameter int tag_w = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  fpi_op_t               in_op,
  input  logic [FPI_DATA_W-1:0] in_a,
  input  logic [FPI_DATA_W-1:0] in_b,
  input  logic [FPI_RD_W-1:0]   in_rd,
  output logic                  fpi_req_valid,
  input  logic                  fpi_req_ready,
  output fpi_op_t               fpi_req_op,
  output logic [FPI_DATA_W-1:0] fpi_req_a,
  output logic [FPI_DATA_W-1:0] fpi_req_b,
  output logic [tag_w-1:0]      fpi_req_tag,
  input  logic                  fpi_resp_valid,
  input  logic [tag_w-1:0]      fpi_resp_tag,
  input  logic [FPI_DATA_W-1:0] fpi_resp_data,
  input  fpi_flags_t            fpi_resp_flags,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [FPI_RD_W-1:0]   wb_rd,
  output logic [FPI_DATA_W-1:0] wb_data,
  output fpi_flags_t            wb_flags,
  output logic                  idle,
  output logic                  proto_err,
  output fpi_flags_t            fflags,
  input  logic                  fflags_clr
);

  logic w_full;
  logic w_empty;
  logic w_issue;
  logic w_retire;
  logic w_comp_ok;
  logic r_proto_err;

  // Requests are held off while reset is asserted so nothing escapes to the FPU
  // during the reset window even though the issue stage may still be presenting an op.
  assign fpi_req_valid = in_valid & ~w_full & rst_n;
  assign in_ready      = fpi_req_ready & ~w_full & rst_n;
  assign fpi_req_op    = in_op;
  assign fpi_req_a     = in_a;
  assign fpi_req_b     = in_b;
  assign w_issue       = in_valid & in_ready;
  assign w_retire      = wb_valid & wb_ready;
  assign idle          = w_empty;
  assign proto_err     = r_proto_err;

  saph_fpi_rob #(
    .depth (depth),
    .tag_w (tag_w)
  ) u_rob (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_alloc      (w_issue),
    .i_alloc_rd   (in_rd),
    .o_alloc_tag  (fpi_req_tag),
    .i_comp       (fpi_resp_valid),
    .i_comp_tag   (fpi_resp_tag),
    .i_comp_data  (fpi_resp_data),
    .i_comp_flags (fpi_resp_flags),
    .o_comp_ok    (w_comp_ok),
    .i_retire     (w_retire),
    .o_head_valid (wb_valid),
    .o_head_rd    (wb_rd),
    .o_head_data  (wb_data),
    .o_head_flags (wb_flags),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // A response to an idle or already-completed slot is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (fpi_resp_valid && !w_comp_ok) begin
      r_proto_err <= 1'b1;
    end
  end

`ifdef SAPH_FPI_REQ_FFLAGS_EN
  fpi_flags_t r_fflags;

  // A clear coinciding with a retire keeps that retire's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fflags <= '0;
    end else if (fflags_clr) begin
      r_fflags <= w_retire ? wb_flags : '0;
    end else if (w_retire) begin
      r_fflags <= r_fflags | wb_flags;
    end
  end

  assign fflags = r_fflags;
`else
  logic w_unused_fflags_clr;

  assign w_unused_fflags_clr = fflags_clr;
  assign fflags              = '0;
`endif

endmodule

// File: tb/tb_saph_fpi_requester.sv
// Self-checking bench for saph_fpi_requester: directed scenarios plus random traffic
// against an in-order queue model of outstanding ops.
module tb_saph_fpi_requester;
  import saph_fpi_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  fpi_op_t          in_op;
  logic [31:0]      in_a, in_b;
  logic [4:0]       in_rd;
  logic             fpi_req_valid;
  logic             fpi_req_ready;
  fpi_op_t          fpi_req_op;
  logic [31:0]      fpi_req_a, fpi_req_b;
  logic [TAG_W-1:0] fpi_req_tag;
  logic             fpi_resp_valid;
  logic [TAG_W-1:0] fpi_resp_tag;
  logic [31:0]      fpi_resp_data;
  fpi_flags_t       fpi_resp_flags;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  fpi_flags_t       wb_flags;
  logic             idle;
  logic             proto_err;
  fpi_flags_t       fflags;
  logic             fflags_clr;

  always #5 clk = ~clk;

  saph_fpi_requester #(.depth(DEPTH), .tag_w(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_rd          (in_rd),
    .fpi_req_valid  (fpi_req_valid),
    .fpi_req_ready  (fpi_req_ready),
    .fpi_req_op     (fpi_req_op),
    .fpi_req_a      (fpi_req_a),
    .fpi_req_b      (fpi_req_b),
    .fpi_req_tag    (fpi_req_tag),
    .fpi_resp_valid (fpi_resp_valid),
    .fpi_resp_tag   (fpi_resp_tag),
    .fpi_resp_data  (fpi_resp_data),
    .fpi_resp_flags (fpi_resp_flags),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_flags       (wb_flags),
    .idle           (idle),
    .proto_err      (proto_err),
    .fflags         (fflags),
    .fflags_clr     (fflags_clr)
  );

  // Reference model: outstanding ops in program order.
  typedef struct {
    int         tag;
    logic [4:0] rd;
    bit         done;
    logic [31:0] data;
    logic [4:0] flags;
  } ent_t;

  ent_t       rob_q[$];
  int         next_tag;
  bit         m_perr;
  logic [4:0] m_ff;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_op          = FPI_ADD;
    in_a           = $urandom;
    in_b           = $urandom;
    in_rd          = 5'($urandom);
    fpi_req_ready  = 1'b1;
    fpi_resp_valid = 1'b0;
    fpi_resp_tag   = '0;
    fpi_resp_data  = '0;
    fpi_resp_flags = '0;
    wb_ready       = 1'b1;
    fflags_clr     = 1'b0;
  endtask

  task automatic set_issue(input fpi_op_t op);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = $urandom;
    in_b     = $urandom;
    in_rd    = 5'($urandom);
  endtask

  task automatic set_resp(input int tag, input logic [4:0] flags);
    fpi_resp_valid = 1'b1;
    fpi_resp_tag   = TAG_W'(tag);
    fpi_resp_data  = $urandom;
    fpi_resp_flags = flags;
  endtask

  // Checks outputs for the current inputs, advances the model across one edge.
  task automatic cycle();
    bit   exp_rdy, exp_wbv, fire, ret;
    int   hit;
    ent_t e;
    #1;
    exp_rdy = fpi_req_ready && (rob_q.size() < DEPTH);
    exp_wbv = (rob_q.size() > 0) && rob_q[0].done;
    check("fpi_req_valid", 64'(fpi_req_valid), 64'(in_valid && rob_q.size() < DEPTH));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("fpi_req_tag", 64'(fpi_req_tag), 64'(next_tag));
    check("fpi_req_a", 64'(fpi_req_a), 64'(in_a));
    check("fpi_req_op", 64'(fpi_req_op), 64'(in_op));
    check("wb_valid", 64'(wb_valid), 64'(exp_wbv));
    if (exp_wbv) begin
      check("wb_rd", 64'(wb_rd), 64'(rob_q[0].rd));
      check("wb_data", 64'(wb_data), 64'(rob_q[0].data));
      check("wb_flags", 64'(wb_flags), 64'(rob_q[0].flags));
    end
    check("idle", 64'(idle), 64'(rob_q.size() == 0));
    check("proto_err", 64'(proto_err), 64'(m_perr));
    check("fflags", 64'(fflags), 64'(m_ff));

    fire = in_valid && exp_rdy;
    ret  = exp_wbv && wb_ready;
    if (fpi_resp_valid) begin
      hit = -1;
      foreach (rob_q[i]) if (rob_q[i].tag == int'(fpi_resp_tag) && !rob_q[i].done) hit = i;
      if (hit >= 0) begin
        e = rob_q[hit];
        e.done  = 1'b1;
        e.data  = fpi_resp_data;
        e.flags = fpi_resp_flags;
        rob_q[hit] = e;
      end else begin
        m_perr = 1'b1;
      end
    end
`ifdef SAPH_FPI_REQ_FFLAGS_EN
    if (fflags_clr) m_ff = ret ? rob_q[0].flags : 5'd0;
    else if (ret)   m_ff = m_ff | rob_q[0].flags;
`endif
    if (ret) void'(rob_q.pop_front());
    if (fire) begin
      e.tag = next_tag; e.rd = in_rd; e.done = 1'b0; e.data = '0; e.flags = '0;
      rob_q.push_back(e);
      next_tag = (next_tag + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    idle_inputs();
    in_valid = 1'b1;
    #2;
    check("rst_fpi_req_valid", 64'(fpi_req_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    check("rst_fflags", 64'(fflags), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rob_q.delete();
    next_tag = 0;
    m_perr   = 1'b0;
    m_ff     = '0;
    idle_inputs();
  endtask

  // Responds to the oldest incomplete op each cycle until empty, within a cycle budget.
  task automatic drain();
    int k;
    k = 0;
    while (rob_q.size() > 0 && k < 60) begin
      idle_inputs();
      foreach (rob_q[i]) if (!rob_q[i].done && !fpi_resp_valid) set_resp(rob_q[i].tag, 5'($urandom));
      cycle();
      k++;
    end
    idle_inputs();
    #1;
    check("drain_idle", 64'(idle), 64'(1));
  endtask

  initial begin
    int undone[$];
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    // 1: reset with in_valid high, then first add gets tag 0.
    do_reset();
    set_issue(FPI_ADD);
    check("first_tag", 64'(fpi_req_tag), 64'(0));
    cycle();
    drain();

    // 2: out-of-order completion, in-order writeback; wb_valid rises at t=11.
    do_reset();
    for (int t = 0; t < 13; t++) begin
      idle_inputs();
      if (t == 0) set_issue(FPI_DIV);
      if (t == 1) set_issue(FPI_ADD);
      if (t == 3) set_resp(1, 5'b00001);
      if (t == 10) set_resp(0, 5'b00100);
      #1;
      if (t == 10) check("t2_wb_before", 64'(wb_valid), 64'(0));
      if (t == 11) check("t2_wb_rise", 64'(wb_valid), 64'(1));
      cycle();
    end
    drain();

    // 3: fill, blocked 5th op, retire tag 0, wrap back to tag 0.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      idle_inputs();
      set_issue(fpi_op_t'($urandom_range(0, 7)));
      cycle();
    end
    idle_inputs();
    set_issue(FPI_MUL);
    #1;
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_req_valid", 64'(fpi_req_valid), 64'(0));
    set_resp(0, 5'b00000);
    cycle();
    fpi_resp_valid = 1'b0;
    cycle();
    #1;
    check("wrap_tag", 64'(fpi_req_tag), 64'(0));
    cycle();
    drain();

    // 4 + 5: stray response to idle slot 2 with a completed head stalled on wb_ready.
    do_reset();
    set_issue(FPI_ADD);
    cycle();
    idle_inputs();
    wb_ready = 1'b0;
    set_resp(0, 5'b01000);
    cycle();
    for (int t = 0; t < 5; t++) begin
      idle_inputs();
      wb_ready = 1'b0;
      if (t == 0) set_resp(2, 5'b11111);
      if (t == 1) set_issue(FPI_SUB);
      if (t == 3) set_resp(1, 5'b00010);
      cycle();
    end
    check("perr_sticky", 64'(proto_err), 64'(1));
    drain();
    check("perr_after_drain", 64'(proto_err), 64'(1));

    // 6: flag accumulation and clear.
    do_reset();
    idle_inputs(); set_issue(FPI_DIV); cycle();
    idle_inputs(); set_issue(FPI_MUL); set_resp(0, 5'b00001); cycle();
    idle_inputs(); set_resp(1, 5'b10000); cycle();
    idle_inputs(); cycle();
    idle_inputs(); #1;
`ifdef SAPH_FPI_REQ_FFLAGS_EN
    check("fflags_acc", 64'(fflags), 64'(5'b10001));
`else
    check("fflags_tied", 64'(fflags), 64'(0));
`endif
    fflags_clr = 1'b1;
    cycle();
    idle_inputs();
    check("fflags_clr", 64'(fflags), 64'(0));

    // Random traffic with a mid-run reset.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      idle_inputs();
      if ($urandom_range(0, 1) == 1) set_issue(fpi_op_t'($urandom_range(0, 7)));
      fpi_req_ready = ($urandom_range(0, 3) != 0);
      wb_ready      = ($urandom_range(0, 3) != 0);
      fflags_clr    = ($urandom_range(0, 15) == 0);
      undone.delete();
      foreach (rob_q[i]) if (!rob_q[i].done) undone.push_back(rob_q[i].tag);
      if (undone.size() > 0 && $urandom_range(0, 1) == 1)
        set_resp(undone[$urandom_range(0, undone.size() - 1)], 5'($urandom));
      else if (c > 450 && $urandom_range(0, 63) == 0)
        set_resp(int'($urandom_range(0, DEPTH - 1)), 5'($urandom));
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
